dtt_buffered_crossbar: RTL and testbench
========================================

// Module: dtt_buffered_crossbar
// PURPOSE
//   Next-generation N_IN x N_OUT crossbar with per-input FIFO buffering,
//   valid/ready backpressure on both sides and per-output arbitration
//   (round-robin or fixed priority). Sits between packet sources and sinks.
//   Contending words wait in their input FIFO instead of being lost.
// PARAMETERS
//   N_IN        4                 number of input ports (>=2)
//   N_OUT       4                 number of output ports (>=2)
//   DATA_WIDTH  32                payload width in bits
//   DEST_WIDTH  $clog2(N_OUT)     destination field width
//   SRC_WIDTH   $clog2(N_IN)      source-index width
//   FIFO_DEPTH  4                 entries per input FIFO (power of 2, >=2)
//   ARB_MODE    0                 0 = round-robin, 1 = fixed priority (lowest index wins)
// PORTS
//   clk        in   1                       single clock, rising edge
//   rst        in   1                       synchronous reset, active-high
//   in_data    in   DATA_WIDTH x N_IN       input payload
//   in_dest    in   DEST_WIDTH x N_IN       destination output index
//   in_valid   in   1 x N_IN                input word present
//   in_ready   out  1 x N_IN                input FIFO can accept
//   out_data   out  DATA_WIDTH x N_OUT      output payload (registered)
//   out_src    out  SRC_WIDTH x N_OUT       input index of out_data
//   out_valid  out  1 x N_OUT               output word present
//   out_ready  in   1 x N_OUT               sink accepts
//   drop       out  1 x N_IN                1-cycle pulse: head word discarded (bad dest)
// BEHAVIOUR
//   Reset (clk edge with rst=1): FIFOs empty, out_valid=0, out_data=0,
//     out_src=0, drop=0, RR pointers = N_IN-1 (input 0 wins first).
//     in_ready=0 while rst=1; all buffered data discarded, nothing emitted.
//   Input: push on in_valid && in_ready; in_ready = !rst && !full.
//     in_valid without in_ready: word not taken, source holds it.
//     Full FIFO: no push, even if head pops in the same cycle.
//     Simultaneous push+pop when not full: count unchanged. Pointers wrap mod FIFO_DEPTH.
//   Output register j loads when (!out_valid[j] || out_ready[j]) and >=1 FIFO
//     head has dest==j. Winner is popped; out_data/out_src written same edge.
//     Load without a winner: out_valid[j] -> 0.
//   Stall: out_valid && !out_ready -> out_data/out_src/out_valid held stable.
//   Each head targets exactly one output, so outputs arbitrate independently.
//   Latency: word accepted at edge t is presented (out_valid=1) after edge t+1
//     at the earliest. Per-input order preserved end to end.
//   Round-robin: search from ptr[j]+1 mod N_IN; ptr[j] <- winner on grant
//     only. Fixed priority: lowest requesting index wins, no pointer.
//   Bad dest (in_dest >= N_OUT, non-power-of-2 N_OUT only): head popped
//     when it reaches the FIFO head, drop[i]=1 for that cycle, no output.
//   Capacity per path: FIFO_DEPTH in FIFO + 1 in output register.
// TESTING
//   1 Burst: one cycle, in0=AAAABBBB->2, in1=CCCCDDDD->2, in2=EEEEFFFF->1,
//     in3=11112222->3, out_ready all 1 -> out1=EEEEFFFF/src2, out3=11112222/src3
//     and out2=AAAABBBB/src0 after edge t+1; out2=CCCCDDDD/src1 after edge t+2.
//   2 Fairness: all inputs stream to out0, out_ready=1 -> src 0,1,2,3,0,...;
//     ARB_MODE=1 -> src always 0 while in0 has data.
//   3 Backpressure: out_ready[0]=0, in0 offers 7 words to out0 -> 5 accepted,
//     then in_ready[0]=0; out_data[0]=word0 held. out_ready=1 -> words 0..6 in order.
//   4 Wrap: 3*FIFO_DEPTH incrementing words from in1 to out3, out_ready
//     toggles 1,0 -> every value received once, in order, none lost.
//   5 Reset mid-traffic: assert rst with FIFOs non-empty -> after that edge
//     out_valid=0, in_ready=0; after release no stale word appears.
//   6 Bad dest: N_OUT=3, in0 dest=3 -> drop[0] pulses once, no out_valid.

Source files
------------

// File: rtl/dtt_buffered_crossbar.sv
// dtt_buffered_crossbar: N_IN x N_OUT crossbar with one FIFO per input,
// valid/ready handshakes on both sides and per-output arbitration.
// Each FIFO head targets one output, so every output arbitrates on its own.

// Per-input FIFO holding {dest, data}. The parent only pushes when the FIFO
// is not full and only pops when it is not empty; the guards here are
// defensive.
module dtt_xbar_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW:0]                 count;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; payload needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module dtt_buffered_crossbar #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = $clog2(N_OUT),
    parameter int SRC_WIDTH  = $clog2(N_IN),
    parameter int FIFO_DEPTH = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_IN*DATA_WIDTH-1:0]  in_data,
    input  logic [N_IN*DEST_WIDTH-1:0]  in_dest,
    input  logic [N_IN-1:0]             in_valid,
    output logic [N_IN-1:0]             in_ready,
    output logic [N_OUT*DATA_WIDTH-1:0] out_data,
    output logic [N_OUT*SRC_WIDTH-1:0]  out_src,
    output logic [N_OUT-1:0]            out_valid,
    input  logic [N_OUT-1:0]            out_ready,
    output logic [N_IN-1:0]             drop
);
    logic [DATA_WIDTH-1:0]               head_data [N_IN];
    logic [DEST_WIDTH-1:0]               head_dest [N_IN];
    logic [31:0]                         dest_ext  [N_IN];
    logic [N_IN-1:0]                     fifo_empty;
    logic [N_IN-1:0]                     fifo_full;
    logic [N_IN-1:0]                     bad;
    logic [N_IN-1:0]                     pop;
    logic [N_OUT-1:0][N_IN-1:0]          req;
    logic [N_OUT-1:0]                    win_vld;
    logic [N_OUT-1:0][SRC_WIDTH-1:0]     win_idx;
    logic [N_OUT-1:0]                    load;
    logic [N_OUT-1:0]                    grant;
    logic [N_OUT-1:0][SRC_WIDTH-1:0]     rr_ptr;
    logic [N_OUT-1:0][DATA_WIDTH-1:0]    data_r;
    logic [N_OUT-1:0][SRC_WIDTH-1:0]     src_r;

    // A full FIFO refuses a push even when its head leaves this cycle.
    assign in_ready = {N_IN{!rst}} & ~fifo_full;
    assign out_data = data_r;
    assign out_src  = src_r;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        logic [DEST_WIDTH+DATA_WIDTH-1:0] rd;

        dtt_xbar_fifo #(
            .WIDTH (DEST_WIDTH + DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[i] && in_ready[i]),
            .wdata ({in_dest[i*DEST_WIDTH +: DEST_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
            .pop   (pop[i]),
            .rdata (rd),
            .empty (fifo_empty[i]),
            .full  (fifo_full[i])
        );

        assign head_data[i] = rd[DATA_WIDTH-1:0];
        assign head_dest[i] = rd[DATA_WIDTH +: DEST_WIDTH];
        // Widened so the range test also works when N_OUT is a power of 2.
        assign dest_ext[i]  = 32'(head_dest[i]);
        assign bad[i]       = !fifo_empty[i] && (dest_ext[i] >= 32'(N_OUT));
    end

    // Request matrix: a valid, well-addressed head requests its one output.
    always_comb begin
        req = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                req[j][i] = !fifo_empty[i] && !bad[i] && (dest_ext[i] == 32'(j));
            end
        end
    end

    // Per-output arbiter: round-robin from ptr+1, or lowest index first.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = '0;
        win_idx = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int k = 0; k < N_IN; k++) begin
                if (ARB_MODE == 0) idx = (int'(rr_ptr[j]) + k + 1) % N_IN;
                else               idx = k;
                if (!win_vld[j] && req[j][idx]) begin
                    win_vld[j] = 1'b1;
                    win_idx[j] = SRC_WIDTH'(idx);
                end
            end
        end
    end

    assign load  = ~out_valid | out_ready;
    assign grant = load & win_vld;

    // Head pops: granted winners plus heads with an out-of-range destination.
    always_comb begin
        pop = bad;
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (grant[j] && (win_idx[j] == SRC_WIDTH'(i))) pop[i] = 1'b1;
            end
        end
    end

    // Output registers: load when empty or draining, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            data_r    <= '0;
            src_r     <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (load[j]) begin
                    out_valid[j] <= win_vld[j];
                    if (win_vld[j]) begin
                        data_r[j] <= head_data[win_idx[j]];
                        src_r[j]  <= win_idx[j];
                    end
                end
            end
        end
    end

    // Round-robin pointers start at N_IN-1 so input 0 wins first; they
    // move only on an actual grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_OUT; j++) rr_ptr[j] <= SRC_WIDTH'(N_IN - 1);
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (grant[j]) rr_ptr[j] <= win_idx[j];
            end
        end
    end

    // Drop pulse: one cycle for each bad head discarded.
    always_ff @(posedge clk) begin
        if (rst) drop <= '0;
        else     drop <= bad;
    end
endmodule

// File: tb/tb_dtt_buffered_crossbar.sv
// Scoreboard bench for dtt_buffered_crossbar: a 4x4 round-robin instance
// and a 4x3 fixed-priority instance (the latter exercises bad destinations).
module tb_dtt_buffered_crossbar;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: 4x4, round-robin
    logic [3:0][31:0] a_in_data;
    logic [3:0][1:0]  a_in_dest;
    logic [3:0]       a_in_valid, a_in_ready;
    logic [3:0][31:0] a_out_data;
    logic [3:0][1:0]  a_out_src;
    logic [3:0]       a_out_valid, a_out_ready, a_drop;

    // Instance B: 4 inputs, 3 outputs, fixed priority
    logic [3:0][31:0] b_in_data;
    logic [3:0][1:0]  b_in_dest;
    logic [3:0]       b_in_valid, b_in_ready;
    logic [2:0][31:0] b_out_data;
    logic [2:0][1:0]  b_out_src;
    logic [2:0]       b_out_valid, b_out_ready;
    logic [3:0]       b_drop;

    dtt_buffered_crossbar #(.N_IN(4), .N_OUT(4), .ARB_MODE(0)) u_a (
        .clk(clk), .rst(rst),
        .in_data(a_in_data), .in_dest(a_in_dest), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_src(a_out_src), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .drop(a_drop)
    );

    dtt_buffered_crossbar #(.N_IN(4), .N_OUT(3), .ARB_MODE(1)) u_b (
        .clk(clk), .rst(rst),
        .in_data(b_in_data), .in_dest(b_in_dest), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .drop(b_drop)
    );

    typedef struct packed {
        logic [1:0]  port;
        logic [1:0]  src;
        logic [31:0] data;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake on an output pops the oldest expectation for it.
    always @(negedge clk) begin
        if (!rst) begin
            for (int j = 0; j < 4; j++) begin
                if (a_out_valid[j] && a_out_ready[j]) begin : mon_a
                    int k;
                    k = -1;
                    for (int m = 0; m < sb_a.size(); m++)
                        if (k < 0 && sb_a[m].port == 2'(j)) k = m;
                    if (k < 0) begin
                        checks++;
                        failures++;
                        $display("FAIL a_unexpected_out%0d: got data=%h src=%0d expected nothing", j, a_out_data[j], a_out_src[j]);
                    end else begin
                        check($sformatf("a_out%0d", j), {30'b0, a_out_src[j], a_out_data[j]},
                              {30'b0, sb_a[k].src, sb_a[k].data});
                        sb_a.delete(k);
                    end
                end
            end
            for (int j = 0; j < 3; j++) begin
                if (b_out_valid[j] && b_out_ready[j]) begin : mon_b
                    int k;
                    k = -1;
                    for (int m = 0; m < sb_b.size(); m++)
                        if (k < 0 && sb_b[m].port == 2'(j)) k = m;
                    if (k < 0) begin
                        checks++;
                        failures++;
                        $display("FAIL b_unexpected_out%0d: got data=%h src=%0d expected nothing", j, b_out_data[j], b_out_src[j]);
                    end else begin
                        check($sformatf("b_out%0d", j), {30'b0, b_out_src[j], b_out_data[j]},
                              {30'b0, sb_b[k].src, sb_b[k].data});
                        sb_b.delete(k);
                    end
                end
            end
        end
    end

    // Offer one word on instance A input i and hold it until accepted.
    task automatic send_a(input int i, input logic [31:0] d, input logic [1:0] dst);
        int n;
        n = 0;
        a_in_data[i]  = d;
        a_in_dest[i]  = dst;
        a_in_valid[i] = 1'b1;
        while (!a_in_ready[i] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_a_timeout in%0d: got no in_ready expected accept", i);
        end
        tick();
        a_in_valid[i] = 1'b0;
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (sb_a.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_a", 64'(sb_a.size()), 64'd0);
    endtask

    task automatic drain_b();
        int n;
        n = 0;
        while (sb_b.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_b", 64'(sb_b.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        rst         = 1'b1;
        a_in_data   = '0;
        a_in_dest   = '0;
        a_in_valid  = '0;
        a_out_ready = '1;
        b_in_data   = '0;
        b_in_dest   = '0;
        b_in_valid  = '0;
        b_out_ready = '1;

        // Reset state
        repeat (3) tick();
        check("rst_a_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_out_data", {a_out_data[1], a_out_data[0]}, 64'd0);
        check("rst_b_drop", 64'(b_drop), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_a_in_ready", 64'(a_in_ready), 64'hF);
        check("post_rst_b_in_ready", 64'(b_in_ready), 64'hF);
        tick();

        // Burst: four inputs in one cycle, two colliding on out2
        sb_a.push_back('{2'd2, 2'd0, 32'hAAAABBBB});
        sb_a.push_back('{2'd2, 2'd1, 32'hCCCCDDDD});
        sb_a.push_back('{2'd1, 2'd2, 32'hEEEEFFFF});
        sb_a.push_back('{2'd3, 2'd3, 32'h11112222});
        a_in_data  = {32'h11112222, 32'hEEEEFFFF, 32'hCCCCDDDD, 32'hAAAABBBB};
        a_in_dest  = {2'd3, 2'd1, 2'd2, 2'd2};
        a_in_valid = 4'hF;
        tick();
        a_in_valid = 4'h0;
        tick();
        check("burst_valid_t1", 64'(a_out_valid), 64'b1110);
        check("burst_out2_t1", 64'(a_out_data[2]), 64'hAAAABBBB);
        tick();
        check("burst_valid_t2", 64'(a_out_valid), 64'b0100);
        check("burst_out2_t2", 64'(a_out_data[2]), 64'hCCCCDDDD);
        drain_a();

        // Fairness: all inputs to out0, two words each, round-robin order
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 4; i++)
                sb_a.push_back('{2'd0, 2'(i), 32'h0200_0000 + 32'(i * 16 + w)});
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4; i++) begin
                a_in_data[i] = 32'h0200_0000 + 32'(i * 16 + w);
                a_in_dest[i] = 2'd0;
            end
            a_in_valid = 4'hF;
            check($sformatf("fair_ready_w%0d", w), 64'(a_in_ready), 64'hF);
            tick();
        end
        a_in_valid = 4'h0;
        drain_a();

        // Backpressure: out0 stalled, five words fit (4 FIFO + 1 register)
        a_out_ready[0] = 1'b0;
        for (int k = 0; k < 7; k++) sb_a.push_back('{2'd0, 2'd0, 32'h3000_0000 + 32'(k)});
        for (int k = 0; k < 5; k++) send_a(0, 32'h3000_0000 + 32'(k), 2'd0);
        a_in_data[0]  = 32'h3000_0005;
        a_in_dest[0]  = 2'd0;
        a_in_valid[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("bp_in_ready_low", 64'(a_in_ready[0]), 64'd0);
            check("bp_out_held", {31'b0, a_out_valid[0], a_out_data[0]}, {31'b0, 1'b1, 32'h3000_0000});
            tick();
        end
        a_out_ready[0] = 1'b1;
        send_a(0, 32'h3000_0005, 2'd0);
        send_a(0, 32'h3000_0006, 2'd0);
        drain_a();

        // Wrap: 3*FIFO_DEPTH words in1 -> out3 with out_ready toggling
        for (int k = 0; k < 12; k++) sb_a.push_back('{2'd3, 2'd1, 32'h4000_0000 + 32'(k)});
        fork
            begin
                for (int c = 0; c < 80; c++) begin
                    a_out_ready[3] = (c % 2 == 0);
                    tick();
                end
                a_out_ready[3] = 1'b1;
            end
            begin
                for (int k = 0; k < 12; k++) send_a(1, 32'h4000_0000 + 32'(k), 2'd3);
            end
        join
        drain_a();

        // Reset mid-traffic: buffered words must vanish
        a_out_ready = '0;
        for (int k = 0; k < 3; k++) send_a(2, 32'h5000_0000 + 32'(k), 2'd1);
        tick();
        check("mid_pre_valid", 64'(a_out_valid), 64'b0010);
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(a_in_ready), 64'd0);
        rst = 1'b0;
        a_out_ready = '1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("mid_no_stale", 64'(a_out_valid), 64'd0);
        end

        // Fixed priority on instance B: in0 keeps winning while it has data
        check("b_ready", 64'(b_in_ready), 64'hF);
        sb_b.push_back('{2'd0, 2'd0, 32'h50});
        sb_b.push_back('{2'd0, 2'd0, 32'h51});
        sb_b.push_back('{2'd0, 2'd0, 32'h52});
        sb_b.push_back('{2'd0, 2'd1, 32'h60});
        sb_b.push_back('{2'd0, 2'd1, 32'h61});
        b_in_dest    = '0;
        b_in_data[0] = 32'h50;
        b_in_data[1] = 32'h60;
        b_in_valid   = 4'b0011;
        tick();
        b_in_data[0] = 32'h51;
        b_in_data[1] = 32'h61;
        tick();
        b_in_data[0] = 32'h52;
        b_in_valid   = 4'b0001;
        tick();
        b_in_valid   = 4'b0000;
        drain_b();

        // Bad destination on a 3-output instance, followed by a good word
        b_in_data[0]  = 32'hBAD;
        b_in_dest[0]  = 2'd3;
        b_in_valid[0] = 1'b1;
        tick();
        sb_b.push_back('{2'd2, 2'd0, 32'h77});
        b_in_data[0]  = 32'h77;
        b_in_dest[0]  = 2'd2;
        tick();
        b_in_valid[0] = 1'b0;
        drops = 0;
        for (int c = 0; c < 10; c++) begin
            drops += $countones(b_drop);
            tick();
        end
        check("bad_dest_drops", 64'(drops), 64'd1);
        drain_b();

        check("final_sb_a", 64'(sb_a.size()), 64'd0);
        check("final_sb_b", 64'(sb_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
